// File: rtl/conv_relu_pool_if.sv
// conv_relu_pool_if: stream bundle between the convolution, the pooling stage and the next layer
//   pixel_vector_in  : NUM_TREES x 32-bit signed conv sums, lane i at [32i+31:32i]
//   pixel_vector_out : NUM_TREES x 8-bit pooled pixels, lane i at [8i+7:8i]
//   pixel_valid_out  : one-cycle strobe qualifying pixel_vector_out
//   frame_done       : one-cycle strobe with the last pooled pixel of a frame
interface conv_relu_pool_if #(parameter int NUM_TREES = 2);
  logic [32*NUM_TREES-1:0] pixel_vector_in;
  logic [8*NUM_TREES-1:0] pixel_vector_out;
  logic pixel_valid_out;
  logic frame_done;
  modport master (output pixel_vector_in, input pixel_vector_out, pixel_valid_out, frame_done);
  modport slave (input pixel_vector_in, output pixel_vector_out, pixel_valid_out, frame_done);
endinterface

// File: rtl/conv_relu_pool.sv
// conv_relu_pool: ReLU + shift/saturate requantization, boundary discard and 2x2/2 max pooling
//   clock : rising-edge clock
//   reset : synchronous, active-low
//   bus   : slave side of conv_relu_pool_if (conv sums in, pooled pixels + strobes out)
module conv_relu_pool #(
  parameter int NUM_TREES = 2,
  parameter int IN_WIDTH = 8,
  parameter int IN_HEIGHT = 8,
  parameter int KERNEL_SIZE = 4,
  parameter int START_DELAY = 28,
  parameter int SHIFT = 4
) (
  input logic clock,
  input logic reset,
  conv_relu_pool_if.slave bus
);
  localparam int OUT_W = IN_WIDTH - KERNEL_SIZE + 1;
  localparam int OUT_H = IN_HEIGHT - KERNEL_SIZE + 1;
  localparam int POOL_W = OUT_W / 2;
  localparam int POOL_H = OUT_H / 2;
  localparam int CW = IN_WIDTH > 1 ? $clog2(IN_WIDTH) : 1;
  localparam int RW = IN_HEIGHT > 1 ? $clog2(IN_HEIGHT) : 1;
  localparam int DW = START_DELAY > 1 ? $clog2(START_DELAY) : 1;
  localparam int PW = POOL_W > 1 ? $clog2(POOL_W) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IN_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IN_HEIGHT - 1);
  localparam logic [CW-1:0] COL_PL = CW'(2 * POOL_W - 1);
  localparam logic [RW-1:0] ROW_PL = RW'(2 * POOL_H - 1);
  localparam logic [DW-1:0] DELAY_LAST = DW'(START_DELAY - 1);
  typedef enum logic {WAIT, RUN} state_t;
  state_t state, state_n;
  logic run;
  logic [DW-1:0] delay;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [NUM_TREES-1:0][31:0] x0;
  logic v0, c0, r0, l0, v1, c1, r1, l1;
  logic [PW-1:0] p0, p1;
  logic [NUM_TREES-1:0][7:0] q1, h, pair, peak, out;
  logic [NUM_TREES-1:0][7:0] lb [2**PW];
  logic valid, done;

  function automatic logic [7:0] requant(input logic signed [31:0] x);
    logic signed [31:0] s;
    s = x >>> SHIFT;
    return x[31] ? 8'd0 : (|s[31:8] ? 8'hff : s[7:0]);
  endfunction

  always_ff @(posedge clock) state <= !reset ? WAIT : state_n;

  always_comb state_n = state == WAIT && delay == DELAY_LAST ? RUN : state;

  always_comb run = state == RUN;

  always_ff @(posedge clock)
    if (!reset) begin
      delay <= '0;
      col <= '0;
      row <= '0;
    end else if (!run) begin
      delay <= delay + 1'b1;
    end else begin
      col <= col == COL_LAST ? '0 : col + 1'b1;
      if (col == COL_LAST) row <= row == ROW_LAST ? '0 : row + 1'b1;
    end

  // input sample stage: positions past the last full 2x2 block are marked invalid here
  always_ff @(posedge clock)
    if (!reset) begin
      x0 <= '0;
      {v0, c0, r0, l0} <= '0;
      p0 <= '0;
    end else begin
      x0 <= bus.pixel_vector_in;
      v0 <= run && (col <= COL_PL) && (row <= ROW_PL);
      c0 <= col[0];
      r0 <= row[0];
      l0 <= col == COL_PL && row == ROW_PL;
      p0 <= PW'(col >> 1);
    end

  always_ff @(posedge clock)
    if (!reset) begin
      q1 <= '0;
      {v1, c1, r1, l1} <= '0;
      p1 <= '0;
    end else begin
      for (int i = 0; i < NUM_TREES; i++) q1[i] <= requant(x0[i]);
      {v1, c1, r1, l1} <= {v0, c0, r0, l0};
      p1 <= p0;
    end

  always_comb begin
    pair = '0;
    peak = '0;
    for (int i = 0; i < NUM_TREES; i++) begin
      pair[i] = h[i] > q1[i] ? h[i] : q1[i];
      peak[i] = lb[p1][i] > pair[i] ? lb[p1][i] : pair[i];
    end
  end

  // even rows only write the line buffer, odd rows only read it, so no index ever collides
  always_ff @(posedge clock)
    if (!reset) begin
      h <= '0;
      out <= '0;
      valid <= 1'b0;
      done <= 1'b0;
      for (int j = 0; j < 2**PW; j++) lb[j] <= '0;
    end else begin
      valid <= v1 && c1 && r1;
      done <= v1 && c1 && r1 && l1;
      if (v1 && !c1) h <= q1;
      if (v1 && c1 && !r1) lb[p1] <= pair;
      if (v1 && c1 && r1) out <= peak;
    end

  assign bus.pixel_vector_out = out;
  assign bus.pixel_valid_out = valid;
  assign bus.frame_done = done;
endmodule

// File: tb/tb_conv_relu_pool.sv
// tb_conv_relu_pool: scoreboard bench over three geometries (requantize, pooling, odd output size)
module tb_conv_relu_pool;
  localparam int SD = 28;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  conv_relu_pool_if #(.NUM_TREES(2)) ia ();
  conv_relu_pool_if #(.NUM_TREES(2)) ib ();
  conv_relu_pool_if #(.NUM_TREES(2)) ic ();

  conv_relu_pool #(.NUM_TREES(2), .IN_WIDTH(8), .IN_HEIGHT(8), .KERNEL_SIZE(4), .START_DELAY(SD), .SHIFT(4))
    dut_a (.clock(clock), .reset(reset), .bus(ia));
  conv_relu_pool #(.NUM_TREES(2), .IN_WIDTH(6), .IN_HEIGHT(6), .KERNEL_SIZE(3), .START_DELAY(SD), .SHIFT(0))
    dut_b (.clock(clock), .reset(reset), .bus(ib));
  conv_relu_pool #(.NUM_TREES(2), .IN_WIDTH(6), .IN_HEIGHT(6), .KERNEL_SIZE(4), .START_DELAY(SD), .SHIFT(0))
    dut_c (.clock(clock), .reset(reset), .bus(ic));

  int W [3] = '{8, 6, 6};
  int H [3] = '{8, 6, 6};
  int K [3] = '{4, 3, 4};
  int SH [3] = '{4, 0, 0};

  logic [15:0] od [3];
  logic ov [3];
  logic ofd [3];
  assign od[0] = ia.pixel_vector_out;
  assign od[1] = ib.pixel_vector_out;
  assign od[2] = ic.pixel_vector_out;
  assign ov[0] = ia.pixel_valid_out;
  assign ov[1] = ib.pixel_valid_out;
  assign ov[2] = ic.pixel_valid_out;
  assign ofd[0] = ia.frame_done;
  assign ofd[1] = ib.frame_done;
  assign ofd[2] = ic.frame_done;

  typedef struct {
    int inst;
    int due;
    logic [15:0] data;
    logic fd;
  } exp_t;
  exp_t sb [$];

  int checks = 0;
  int errors = 0;
  int k = 0;

  function automatic logic signed [31:0] stim(int inst, int f, int c, int r, int lane);
    if (inst == 0) begin
      if (lane == 1) return 32'sh320;
      return f % 4 == 0 ? -32'sd5 : f % 4 == 1 ? 32'sh0A0 : f % 4 == 2 ? 32'sh1000 : 32'sh7FFFFFFF;
    end
    if (inst == 1) begin
      if (c < 4 && r < 4) return lane == 0 ? 32'(r * 4 + c) : 32'(100 - (r * 4 + c));
      return f == 0 ? 32'sd0 : 32'sh7FFFFFFF;
    end
    return (c < 3 && r < 3 && (c == 2 || r == 2)) ? 32'sd255 : 32'sd1;
  endfunction

  function automatic int rq(logic signed [31:0] x, int sh);
    int v;
    if (x < 0) return 0;
    v = x >>> sh;
    return v > 255 ? 255 : v;
  endfunction

  function automatic logic [7:0] pool(int inst, int f, int c, int r, int lane);
    int m;
    m = 0;
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++) begin
        int v;
        v = rq(stim(inst, f, c - dc, r - dr, lane), SH[inst]);
        if (v > m) m = v;
      end
    return 8'(m);
  endfunction

  task automatic chk(string tag, int inst, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s[%0d]: observed %0h expected %0h at k=%0d", tag, inst, got, exp, k);
    end
  endtask

  task automatic drive();
    logic [63:0] v [3];
    for (int i = 0; i < 3; i++) begin
      int n, c, r, f, pw, ph;
      n = k - SD;
      pw = (W[i] - K[i] + 1) / 2;
      ph = (H[i] - K[i] + 1) / 2;
      if (reset && n >= 0) begin
        c = n % W[i];
        r = (n / W[i]) % H[i];
        f = n / (W[i] * H[i]);
        v[i] = {stim(i, f, c, r, 1), stim(i, f, c, r, 0)};
        if (c % 2 == 1 && r % 2 == 1 && c < 2 * pw && r < 2 * ph)
          sb.push_back('{i, k + 2, {pool(i, f, c, r, 1), pool(i, f, c, r, 0)},
                        c == 2 * pw - 1 && r == 2 * ph - 1});
      end else begin
        v[i] = {$urandom, $urandom};
      end
    end
    ia.pixel_vector_in = v[0];
    ib.pixel_vector_in = v[1];
    ic.pixel_vector_in = v[2];
  endtask

  task automatic check();
    for (int i = 0; i < 3; i++) begin
      int j;
      j = -1;
      if (!reset) begin
        chk("rst_pixel", i, 32'(od[i]), 32'd0);
        chk("rst_valid", i, 32'(ov[i]), 32'd0);
        chk("rst_done", i, 32'(ofd[i]), 32'd0);
      end else begin
        for (int e = 0; e < sb.size(); e++)
          if (sb[e].inst == i && sb[e].due == k) j = e;
        if (j >= 0) begin
          chk("valid", i, 32'(ov[i]), 32'd1);
          chk("pixel", i, 32'(od[i]), 32'(sb[j].data));
          chk("frame_done", i, 32'(ofd[i]), 32'(sb[j].fd));
          sb.delete(j);
        end else begin
          chk("idle_valid", i, 32'(ov[i]), 32'd0);
          chk("idle_done", i, 32'(ofd[i]), 32'd0);
        end
      end
    end
  endtask

  task automatic tick();
    drive();
    @(posedge clock);
    @(negedge clock);
    if (!reset) sb.delete();
    check();
    if (!reset) k = 0;
    else k++;
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    while (k < 300) tick();
    while ((k - SD) % 36 != 15) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    repeat (SD + 3 * 36) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_relu_pool.md
# conv_relu_pool

Post-processing stage directly downstream of `convolution_25D`. It consumes the free-running `pixel_vector_out` stream of NUM_TREES 32-bit signed convolution sums and applies three operations per tree:
- ReLU, then an arithmetic right shift with saturation to 8 bits.
- Discarding of window positions that straddle a row or frame boundary.
- 2x2 stride-2 max pooling.

It emits one 8-bit pooled pixel per tree with a valid strobe, ready to feed the next layer's shift register.

## Interface
- NUM_TREES, 2, number of kernels / parallel lanes
- IN_WIDTH, 8, row length of the image fed to the convolution (raster pixels per row)
- IN_HEIGHT, 8, rows per frame
- KERNEL_SIZE, 4, square kernel edge; OUT_W = IN_WIDTH-KERNEL_SIZE+1, OUT_H = IN_HEIGHT-KERNEL_SIZE+1
- START_DELAY, 28, cycles from reset release until the convolution presents the window at raster position 0
- SHIFT, 4, requantization right shift (0..24)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low
- pixel_vector_in  in  32*NUM_TREES  conv sums; lane i = bits [32i+31:32i], two's complement
- pixel_vector_out  out  8*NUM_TREES  pooled pixels; lane i = bits [8i+7:8i]
- pixel_valid_out  out  1  one-cycle strobe, pixel_vector_out valid
- frame_done  out  1  one-cycle strobe with the last pooled pixel of a frame

## Operation
- Reset is synchronous and active-low; this is fixed. Any edge sampling reset=0 clears all state and forces pixel_vector_out=0, pixel_valid_out=0, frame_done=0, state=WAIT, and all counters to 0.
- Cycle index k=0 is the first edge with reset=1.
- FSM states:
  - WAIT: delay counter increments every cycle; leave for RUN when the counter reaches START_DELAY-1.
  - RUN: raster counters col (0..IN_WIDTH-1) and row (0..IN_HEIGHT-1) advance once per cycle. col wraps to 0 and increments row; row wraps to 0 at frame end. RUN continues indefinitely, with back-to-back frames and no gaps.
- Position valid when col<OUT_W and row<OUT_H; all other cycles are ignored and leave the pool state unchanged.
- Requantize, per lane, on every valid position:
  - q = (x<0) ? 0 : x>>>SHIFT.
  - q saturates to 255 if it is above 255.
- Pool position: pc=col>>1, pr=row>>1.
  - The last column is dropped if OUT_W is odd; the last row is dropped if OUT_H is odd. Dropped positions never affect outputs.
- Even col: hold h=q.
- Odd col, even row: line buffer LB[pc] = max(h,q). The buffer has OUT_W/2 entries x 8 bits per lane.
- Odd col, odd row: result = max(LB[pc], h, q), which is emitted.
- frame_done is asserted with the emission at pc=OUT_W/2-1, pr=OUT_H/2-1.
- Reset asserted mid-frame: the partial frame is discarded, no strobe is emitted, and the block restarts in WAIT.

## Timing
- Stage 1 registers q for all lanes together with valid, col parity, row parity and pc.
- Stage 2 does the compare / line-buffer access and registers the outputs.
- Latency: the input presented in cycle c (sampled at edge c) produces an output visible after edge c+2, i.e. during cycle c+2.
- pixel_valid_out is high for exactly one cycle per pooled pixel. pixel_vector_out holds its last value while not valid.
- At most one emission every 2 cycles; in steady state there are OUT_W/2 emissions per odd pooled row.
- An LB read and write to the same index never occur in the same cycle. Even rows only write and odd rows only read.
- The line buffer is not cleared between frames; even rows fully overwrite it before any read.

## Test plan
- Reset values: hold reset=0 for 3 cycles with random input. Required: pixel_vector_out=0, pixel_valid_out=0, frame_done=0 on every cycle. Then release reset: no strobe before cycle START_DELAY+2.
- Requantize, SHIFT=4, lane 0:
  - -5 -> 0.
  - 0x00000A0 -> 10.
  - 0x00001000 -> 255 (saturated).
  - 0x7FFFFFFF -> 255.
  - Present these as constant frames; the pooled output must equal each value.
- Pooling with IN_WIDTH=IN_HEIGHT=6, KERNEL_SIZE=3, SHIFT=0, OUT 4x4. Lane0 value = row*4+col at valid positions; lane1 = 100-(row*4+col).
  - Required lane0 outputs: 5, 7, 13, 15.
  - Required lane1 outputs: 100, 98, 92, 90.
  - Exactly 4 strobes per frame; frame_done with the 4th.
- Boundary discard: garbage input (0x7FFFFFFF) in all invalid columns and rows of the previous case. Required: identical results to the previous case.
- Odd output size with IN_WIDTH=IN_HEIGHT=6, KERNEL_SIZE=4, OUT 3x3. Set the last column and last row to 255, everything else 1. Required: a single output of 1 per lane per frame, with frame_done.
- Reset mid-frame: assert reset for 1 cycle during pooled row 1. Required: no strobe until a full fresh frame; that frame's outputs are identical to the undisturbed case.
